// File: rtl/common_def.sv
// ============================================================================
//  Module   : common_def (package)
//  Purpose  : Shared codes, issue bundle layout and FSM state for issue_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package common_def;

    localparam int XLEN_DEF   = 32;
    localparam int NREG_DEF   = 32;
    localparam int REG_W      = $clog2(NREG_DEF);
    localparam int OP_W_DEF   = 6;
    localparam int UNIT_W_DEF = 3;

    localparam logic [UNIT_W_DEF-1:0] EX_ALU_UNIT = 3'd0;
    localparam logic [UNIT_W_DEF-1:0] EX_BR_UNIT  = 3'd1;
    localparam logic [UNIT_W_DEF-1:0] EX_MEM_UNIT = 3'd2;
    localparam logic [UNIT_W_DEF-1:0] EX_ERR_UNIT = 3'd7;

    localparam logic [OP_W_DEF-1:0] ALU_NOP  = 6'd0;
    localparam logic [OP_W_DEF-1:0] ALU_ADD  = 6'd1;
    localparam logic [OP_W_DEF-1:0] ALU_ADDI = 6'd2;
    localparam logic [OP_W_DEF-1:0] OP_BEQ   = 6'd16;
    localparam logic [OP_W_DEF-1:0] OP_LOAD  = 6'd32;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        WAIT_CF = 1'b1
    } state_t;

    typedef struct packed {
        logic [OP_W_DEF-1:0]   op;
        logic [UNIT_W_DEF-1:0] ex_unit;
        logic                  rs1_en;
        logic                  rs2_en;
        logic [REG_W-1:0]      rs1;
        logic [REG_W-1:0]      rs2;
        logic                  rd_en;
        logic [REG_W-1:0]      rd;
        logic [XLEN_DEF-1:0]   imm;
        logic                  imm_en;
        logic                  pc_en;
        logic [XLEN_DEF-1:0]   offset;
        logic [2:0]            width;
        logic [XLEN_DEF-1:0]   pc;
    } issue_bundle_t;

endpackage

`default_nettype wire

// File: rtl/issue_ctrl_scoreboard.sv
// ============================================================================
//  Module   : issue_ctrl_scoreboard
//  Purpose  : Pending-destination busy vector with writeback-bypassed reads.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module issue_ctrl_scoreboard #(
    parameter  int NREG  = 32,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] a_idx,
    input  logic [IDX_W-1:0] b_idx,
    input  logic [IDX_W-1:0] c_idx,
    output logic             a_busy,
    output logic             b_busy,
    output logic             c_busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_eff;
    logic [NREG-1:0] w_busy_nxt;

    // Writeback in flight this cycle already releases its register for readers.
    always_comb begin
        w_busy_eff = r_busy;
        if (clr_en) begin
            w_busy_eff[clr_idx] = 1'b0;
        end
    end

    // Set applied after clear so a same-register collision leaves it busy.
    always_comb begin
        w_busy_nxt = w_busy_eff;
        if (set_en && (set_idx != '0)) begin
            w_busy_nxt[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign a_busy = w_busy_eff[a_idx];
    assign b_busy = w_busy_eff[b_idx];
    assign c_busy = w_busy_eff[c_idx];

endmodule

`default_nettype wire

// File: rtl/issue_ctrl.sv
// ============================================================================
//  Module   : issue_ctrl
//  Purpose  : Decode-side issue stage: hazard hold-off, control-flow wait and
//             registered bundle towards the execute units.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module issue_ctrl
    import common_def::*;
#(
    parameter  int XLEN   = 32,
    parameter  int NREG   = 32,
    parameter  int OP_W   = 6,
    parameter  int UNIT_W = 3,
    localparam int IDX_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [UNIT_W-1:0] in_ex_unit,
    input  logic              in_rs1_en,
    input  logic              in_rs2_en,
    input  logic [IDX_W-1:0]  in_rs1,
    input  logic [IDX_W-1:0]  in_rs2,
    input  logic              in_rd_en,
    input  logic [IDX_W-1:0]  in_rd,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_imm_en,
    input  logic              in_pc_en,
    input  logic [XLEN-1:0]   in_offset,
    input  logic [2:0]        in_width,
    input  logic              in_stall,
    input  logic [XLEN-1:0]   in_pc,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [OP_W-1:0]   iss_op,
    output logic [UNIT_W-1:0] iss_ex_unit,
    output logic              iss_rs1_en,
    output logic              iss_rs2_en,
    output logic [IDX_W-1:0]  iss_rs1,
    output logic [IDX_W-1:0]  iss_rs2,
    output logic              iss_rd_en,
    output logic [IDX_W-1:0]  iss_rd,
    output logic [XLEN-1:0]   iss_imm,
    output logic              iss_imm_en,
    output logic              iss_pc_en,
    output logic [XLEN-1:0]   iss_offset,
    output logic [2:0]        iss_width,
    output logic [XLEN-1:0]   iss_pc,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_rd,
    input  logic              cf_done,
    output logic              cf_err
);

    state_t        r_state;
    issue_bundle_t r_iss;
    logic          r_iss_valid;
    logic          r_cf_err;

    issue_bundle_t w_in;
    logic          w_rs1_busy;
    logic          w_rs2_busy;
    logic          w_rd_busy;
    logic          w_hz;
    logic          w_accept;

    issue_ctrl_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (w_accept & in_rd_en),
        .set_idx (in_rd),
        .clr_en  (wb_en),
        .clr_idx (wb_rd),
        .a_idx   (in_rs1),
        .b_idx   (in_rs2),
        .c_idx   (in_rd),
        .a_busy  (w_rs1_busy),
        .b_busy  (w_rs2_busy),
        .c_busy  (w_rd_busy)
    );

    assign w_in = '{op: in_op, ex_unit: in_ex_unit, rs1_en: in_rs1_en,
                    rs2_en: in_rs2_en, rs1: in_rs1, rs2: in_rs2,
                    rd_en: in_rd_en, rd: in_rd, imm: in_imm,
                    imm_en: in_imm_en, pc_en: in_pc_en, offset: in_offset,
                    width: in_width, pc: in_pc};

    assign w_hz = (in_rs1_en & w_rs1_busy) | (in_rs2_en & w_rs2_busy) |
                  (in_rd_en & (in_rd != '0) & w_rd_busy);

    assign in_ready = !rst && (r_state == RUN) && (!r_iss_valid || iss_ready) && !w_hz;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= RUN;
            r_iss_valid     <= 1'b0;
            r_iss           <= '0;
            r_iss.op        <= ALU_NOP;
            r_iss.ex_unit   <= EX_ERR_UNIT;
            r_cf_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_iss_valid <= 1'b1;
                r_iss       <= w_in;
            end else if (iss_ready) begin
                r_iss_valid <= 1'b0;
            end

            case (r_state)
                RUN: begin
                    if (cf_done) begin
                        r_cf_err <= 1'b1;
                    end
                    if (w_accept && in_stall) begin
                        r_state <= WAIT_CF;
                    end
                end
                WAIT_CF: begin
                    if (cf_done) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign iss_valid   = r_iss_valid;
    assign iss_op      = r_iss.op;
    assign iss_ex_unit = r_iss.ex_unit;
    assign iss_rs1_en  = r_iss.rs1_en;
    assign iss_rs2_en  = r_iss.rs2_en;
    assign iss_rs1     = r_iss.rs1;
    assign iss_rs2     = r_iss.rs2;
    assign iss_rd_en   = r_iss.rd_en;
    assign iss_rd      = r_iss.rd;
    assign iss_imm     = r_iss.imm;
    assign iss_imm_en  = r_iss.imm_en;
    assign iss_pc_en   = r_iss.pc_en;
    assign iss_offset  = r_iss.offset;
    assign iss_width   = r_iss.width;
    assign iss_pc      = r_iss.pc;
    assign cf_err      = r_cf_err;

endmodule

`default_nettype wire
